// File: rtl/aap_writeback_if.sv
// Execute/memory-side bus into the aap_writeback stage: retiring op handshake and load returns.
// master = execute/memory driver, slave = writeback stage.
interface aap_writeback_if;
    // Handshake: an op transfers on the clock edge where ex_valid && ex_ready are both high;
    // ex_valid may not depend on ex_ready, and the op must hold stable while ex_valid && !ex_ready.
    // mem_rvalid has no back-pressure: every asserted cycle is one in-order load return.
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_d_we;
    logic [5:0]  ex_d_regnum;
    logic [15:0] ex_d_data;
    logic        ex_b_we;
    logic [5:0]  ex_b_regnum;
    logic [15:0] ex_b_data;
    logic        ex_is_load;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;

    modport master (
        output ex_valid, ex_d_we, ex_d_regnum, ex_d_data,
        output ex_b_we, ex_b_regnum, ex_b_data, ex_is_load,
        output mem_rvalid, mem_rdata,
        input  ex_ready
    );

    modport slave (
        input  ex_valid, ex_d_we, ex_d_regnum, ex_d_data,
        input  ex_b_we, ex_b_regnum, ex_b_data, ex_is_load,
        input  mem_rvalid, mem_rdata,
        output ex_ready
    );
endinterface

// File: rtl/aap_writeback.sv
// Writeback stage: registers execute results onto the regd/regb ports, tracks loads in an in-order
// FIFO plus 16-bit pending scoreboard, and writes returning load data on rega. Option: AAP_WB_BYPASS_EN.
`ifndef STATE_HALTED
`define STATE_HALTED 3'd7
`endif

module aap_writeback #(
    parameter int LDQ_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   state,
    aap_writeback_if.slave bus,
    input  logic [5:0]   rd_regnum0,
    input  logic [5:0]   rd_regnum1,
    input  logic [5:0]   rd_regnum2,
    output logic         hazard_stall,
    output logic [5:0]   rega_wregnum,
    output logic [15:0]  rega_wdata,
    output logic         rega_we,
    output logic [5:0]   regb_wregnum,
    output logic [15:0]  regb_wdata,
    output logic         regb_we,
    output logic [5:0]   regd_wregnum,
    output logic [15:0]  regd_wdata,
    output logic         regd_we,
    output logic         ldq_err
`ifdef AAP_WB_BYPASS_EN
    ,
    output logic         fwd_valid,
    output logic [15:0]  fwd_data
`endif
);

    localparam int PW = (LDQ_DEPTH > 1) ? $clog2(LDQ_DEPTH) : 1;
    localparam logic [PW:0] DEPTH_C = (PW+1)'(LDQ_DEPTH);

    logic [3:0]    ldq_q [LDQ_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [15:0]   pending_q, pending_d;
    logic          ldq_err_q, ldq_err_d;

    logic          rega_we_q, rega_we_d;
    logic [5:0]    rega_wregnum_q, rega_wregnum_d;
    logic [15:0]   rega_wdata_q, rega_wdata_d;
    logic          regb_we_q, regb_we_d;
    logic [5:0]    regb_wregnum_q, regb_wregnum_d;
    logic [15:0]   regb_wdata_q, regb_wdata_d;
    logic          regd_we_q, regd_we_d;
    logic [5:0]    regd_wregnum_q, regd_wregnum_d;
    logic [15:0]   regd_wdata_q, regd_wdata_d;

    logic          full, empty, halted;
    logic          ex_ready_w, accept, push, pop;
    logic [3:0]    head;
    logic [2:0]    haz;
    logic          unused_bits;

    assign full   = (count_q == DEPTH_C);
    assign empty  = (count_q == '0);
    assign halted = (state == `STATE_HALTED);
    assign head   = ldq_q[rd_ptr_q];

    // WAW terms keep a younger write from being overtaken by an older outstanding load.
    assign ex_ready_w = rst && !halted
                        && !(bus.ex_is_load && full)
                        && !(bus.ex_d_we && pending_q[bus.ex_d_regnum[3:0]])
                        && !(bus.ex_b_we && pending_q[bus.ex_b_regnum[3:0]]);
    assign bus.ex_ready = ex_ready_w;

    assign accept = bus.ex_valid && ex_ready_w;
    assign push   = accept && bus.ex_is_load;
    assign pop    = bus.mem_rvalid && !empty;

`ifdef AAP_WB_BYPASS_EN
    assign haz[0] = pending_q[rd_regnum0[3:0]] && !(pop && head == rd_regnum0[3:0]);
    assign haz[1] = pending_q[rd_regnum1[3:0]] && !(pop && head == rd_regnum1[3:0]);
    assign haz[2] = pending_q[rd_regnum2[3:0]] && !(pop && head == rd_regnum2[3:0]);
    assign fwd_valid = pop && (head == rd_regnum0[3:0] || head == rd_regnum1[3:0]
                               || head == rd_regnum2[3:0]);
    assign fwd_data  = bus.mem_rdata;
`else
    assign haz[0] = pending_q[rd_regnum0[3:0]];
    assign haz[1] = pending_q[rd_regnum1[3:0]];
    assign haz[2] = pending_q[rd_regnum2[3:0]];
`endif
    assign hazard_stall = |haz;

    assign unused_bits = ^{rd_regnum0[5:4], rd_regnum1[5:4], rd_regnum2[5:4]};

    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        pending_d      = pending_q;
        ldq_err_d      = ldq_err_q || (bus.mem_rvalid && empty);

        regd_we_d      = 1'b0;
        regd_wregnum_d = regd_wregnum_q;
        regd_wdata_d   = regd_wdata_q;
        regb_we_d      = 1'b0;
        regb_wregnum_d = regb_wregnum_q;
        regb_wdata_d   = regb_wdata_q;
        rega_we_d      = 1'b0;
        rega_wregnum_d = rega_wregnum_q;
        rega_wdata_d   = rega_wdata_q;

        if (accept) begin
            regb_we_d      = bus.ex_b_we;
            regb_wregnum_d = {2'b00, bus.ex_b_regnum[3:0]};
            regb_wdata_d   = bus.ex_b_data;
            if (!bus.ex_is_load) begin
                regd_we_d      = bus.ex_d_we;
                regd_wregnum_d = {2'b00, bus.ex_d_regnum[3:0]};
                regd_wdata_d   = bus.ex_d_data;
            end
        end

        if (pop) begin
            rd_ptr_d        = rd_ptr_q + PW'(1);
            pending_d[head] = 1'b0;
            // A same-cycle regd/regb write to this register is younger and takes precedence.
            rega_we_d      = !((regd_we_d && regd_wregnum_d[3:0] == head)
                               || (regb_we_d && regb_wregnum_d[3:0] == head));
            rega_wregnum_d = {2'b00, head};
            rega_wdata_d   = bus.mem_rdata;
        end

        // Set after clear so a new load to the register just returned stays pending.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            pending_d[bus.ex_d_regnum[3:0]] = 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ldq_q[wr_ptr_q] <= bus.ex_d_regnum[3:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            pending_q      <= '0;
            ldq_err_q      <= 1'b0;
            rega_we_q      <= 1'b0;
            rega_wregnum_q <= '0;
            rega_wdata_q   <= '0;
            regb_we_q      <= 1'b0;
            regb_wregnum_q <= '0;
            regb_wdata_q   <= '0;
            regd_we_q      <= 1'b0;
            regd_wregnum_q <= '0;
            regd_wdata_q   <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            pending_q      <= pending_d;
            ldq_err_q      <= ldq_err_d;
            rega_we_q      <= rega_we_d;
            rega_wregnum_q <= rega_wregnum_d;
            rega_wdata_q   <= rega_wdata_d;
            regb_we_q      <= regb_we_d;
            regb_wregnum_q <= regb_wregnum_d;
            regb_wdata_q   <= regb_wdata_d;
            regd_we_q      <= regd_we_d;
            regd_wregnum_q <= regd_wregnum_d;
            regd_wdata_q   <= regd_wdata_d;
        end
    end

    assign rega_we      = rega_we_q;
    assign rega_wregnum = rega_wregnum_q;
    assign rega_wdata   = rega_wdata_q;
    assign regb_we      = regb_we_q;
    assign regb_wregnum = regb_wregnum_q;
    assign regb_wdata   = regb_wdata_q;
    assign regd_we      = regd_we_q;
    assign regd_wregnum = regd_wregnum_q;
    assign regd_wdata   = regd_wdata_q;
    assign ldq_err      = ldq_err_q;

endmodule

// File: tb/tb_aap_writeback.sv
// Bench for aap_writeback: directed stimulus, expected register-file writes queued per port,
// a negedge monitor pops and compares each write the DUT presents.
`ifndef STATE_HALTED
`define STATE_HALTED 3'd7
`endif

module tb_aap_writeback;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  state;
    logic [5:0]  rd_regnum0, rd_regnum1, rd_regnum2;
    logic        hazard_stall;
    logic [5:0]  rega_wregnum, regb_wregnum, regd_wregnum;
    logic [15:0] rega_wdata, regb_wdata, regd_wdata;
    logic        rega_we, regb_we, regd_we;
    logic        ldq_err;
`ifdef AAP_WB_BYPASS_EN
    logic        fwd_valid;
    logic [15:0] fwd_data;
`endif

    int checks = 0;
    int errors = 0;
    // entry = {port[1:0], regnum[5:0], data[15:0]}; port 0=regd, 1=regb, 2=rega
    logic [23:0] exp_q[$];

    aap_writeback_if bus_if();

    aap_writeback #(.LDQ_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .state        (state),
        .bus          (bus_if),
        .rd_regnum0   (rd_regnum0),
        .rd_regnum1   (rd_regnum1),
        .rd_regnum2   (rd_regnum2),
        .hazard_stall (hazard_stall),
        .rega_wregnum (rega_wregnum),
        .rega_wdata   (rega_wdata),
        .rega_we      (rega_we),
        .regb_wregnum (regb_wregnum),
        .regb_wdata   (regb_wdata),
        .regb_we      (regb_we),
        .regd_wregnum (regd_wregnum),
        .regd_wdata   (regd_wdata),
        .regd_we      (regd_we),
        .ldq_err      (ldq_err)
`ifdef AAP_WB_BYPASS_EN
        ,
        .fwd_valid    (fwd_valid),
        .fwd_data     (fwd_data)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers / driver tasks ----------------
    function automatic logic [23:0] mk(input logic [1:0] p, input logic [5:0] r, input logic [15:0] d);
        return {p, r, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic mon_cmp(input string name, input logic [23:0] act);
        logic [23:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected write: got %0h expected none", name, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                errors++;
                $display("FAIL %s write: got %0h expected %0h", name, act, e);
            end
        end
    endtask

    task automatic set_op(input logic ld, input logic dwe, input logic [5:0] dreg,
                          input logic [15:0] ddat, input logic bwe, input logic [5:0] breg,
                          input logic [15:0] bdat);
        bus_if.ex_valid    = 1'b1;
        bus_if.ex_is_load  = ld;
        bus_if.ex_d_we     = dwe;
        bus_if.ex_d_regnum = dreg;
        bus_if.ex_d_data   = ddat;
        bus_if.ex_b_we     = bwe;
        bus_if.ex_b_regnum = breg;
        bus_if.ex_b_data   = bdat;
    endtask

    task automatic clr_op();
        bus_if.ex_valid   = 1'b0;
        bus_if.ex_is_load = 1'b0;
        bus_if.ex_d_we    = 1'b0;
        bus_if.ex_b_we    = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (regd_we === 1'b1) mon_cmp("regd", mk(2'd0, regd_wregnum, regd_wdata));
        if (regb_we === 1'b1) mon_cmp("regb", mk(2'd1, regb_wregnum, regb_wdata));
        if (rega_we === 1'b1) mon_cmp("rega", mk(2'd2, rega_wregnum, rega_wdata));
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0;
        state = 3'd0;
        rd_regnum0 = 6'd0;
        rd_regnum1 = 6'd0;
        rd_regnum2 = 6'd0;
        bus_if.mem_rvalid = 1'b0;
        bus_if.mem_rdata  = 16'h0;
        set_op(1'b0, 1'b1, 6'd3, 16'h1111, 1'b1, 6'd1, 16'h2222);

        // reset held 2 cycles with ex_valid high
        tick();
        chk("rst_ex_ready", {63'd0, bus_if.ex_ready}, 64'd0);
        tick();
        chk("rst_we", {61'd0, rega_we, regb_we, regd_we}, 64'd0);
        chk("rst_regs", {rega_wregnum, regb_wregnum, regd_wregnum, rega_wdata, regb_wdata, regd_wdata[9:0]}, 64'd0);
        chk("rst_hazard", {63'd0, hazard_stall}, 64'd0);
        chk("rst_ldq_err", {63'd0, ldq_err}, 64'd0);
        chk("rst_ex_ready2", {63'd0, bus_if.ex_ready}, 64'd0);
        clr_op();
        rst = 1'b1;
        tick();

        // ALU op: upper regnum bits dropped on output
        set_op(1'b0, 1'b1, 6'h33, 16'h1234, 1'b1, 6'h01, 16'h0102);
        #1 chk("alu_ready", {63'd0, bus_if.ex_ready}, 64'd1);
        exp_q.push_back(mk(2'd0, 6'h03, 16'h1234));
        exp_q.push_back(mk(2'd1, 6'h01, 16'h0102));
        tick();
        clr_op();
        chk("alu_rega_we", {63'd0, rega_we}, 64'd0);
        tick();

        // single load to R5 and its return
        set_op(1'b1, 1'b0, 6'd5, 16'h0, 1'b0, 6'd0, 16'h0);
        rd_regnum0 = 6'd5;
        #1 chk("ld5_ready", {63'd0, bus_if.ex_ready}, 64'd1);
        chk("ld5_haz_before", {63'd0, hazard_stall}, 64'd0);
        tick();
        clr_op();
        chk("ld5_haz_pending", {63'd0, hazard_stall}, 64'd1);
        tick();
        chk("ld5_haz_hold", {63'd0, hazard_stall}, 64'd1);
        bus_if.mem_rvalid = 1'b1;
        bus_if.mem_rdata  = 16'hBEEF;
        exp_q.push_back(mk(2'd2, 6'd5, 16'hBEEF));
        #1;
`ifdef AAP_WB_BYPASS_EN
        chk("ld5_haz_ret_bypass", {63'd0, hazard_stall}, 64'd0);
        chk("ld5_fwd", {47'd0, fwd_valid, fwd_data}, {47'd0, 1'b1, 16'hBEEF});
`else
        chk("ld5_haz_ret", {63'd0, hazard_stall}, 64'd1);
`endif
        tick();
        bus_if.mem_rvalid = 1'b0;
        #1 chk("ld5_haz_after", {63'd0, hazard_stall}, 64'd0);
        rd_regnum0 = 6'd0;

        // fill FIFO with R1..R4
        for (int i = 1; i <= 4; i++) begin
            set_op(1'b1, 1'b0, 6'(i), 16'h0, 1'b0, 6'd0, 16'h0);
            #1 chk("fill_ready", {63'd0, bus_if.ex_ready}, 64'd1);
            tick();
        end
        set_op(1'b1, 1'b0, 6'd7, 16'h0, 1'b0, 6'd0, 16'h0);
        #1 chk("full_blocks", {63'd0, bus_if.ex_ready}, 64'd0);
        bus_if.mem_rvalid = 1'b1;
        bus_if.mem_rdata  = 16'hA001;
        exp_q.push_back(mk(2'd2, 6'd1, 16'hA001));
        #1 chk("full_pop_blocks", {63'd0, bus_if.ex_ready}, 64'd0);
        tick();
        bus_if.mem_rdata = 16'hA002;
        exp_q.push_back(mk(2'd2, 6'd2, 16'hA002));
        #1 chk("push_pop_ready", {63'd0, bus_if.ex_ready}, 64'd1);
        tick();
        clr_op();
        bus_if.mem_rdata = 16'hA003;
        exp_q.push_back(mk(2'd2, 6'd3, 16'hA003));
        tick();
        bus_if.mem_rdata = 16'hA004;
        exp_q.push_back(mk(2'd2, 6'd4, 16'hA004));
        tick();
        bus_if.mem_rvalid = 1'b0;
        rd_regnum2 = 6'd7;
        #1 chk("r7_pending", {63'd0, hazard_stall}, 64'd1);
        tick();
        bus_if.mem_rvalid = 1'b1;
        bus_if.mem_rdata  = 16'hA007;
        exp_q.push_back(mk(2'd2, 6'd7, 16'hA007));
        tick();
        bus_if.mem_rvalid = 1'b0;
        rd_regnum2 = 6'd0;
        #1 chk("r7_cleared", {63'd0, hazard_stall}, 64'd0);

        // WAW block on R6 and halted-state drain
        set_op(1'b1, 1'b0, 6'd6, 16'h0, 1'b0, 6'd0, 16'h0);
        tick();
        set_op(1'b0, 1'b1, 6'd6, 16'h6666, 1'b0, 6'd0, 16'h0);
        rd_regnum1 = 6'd6;
        #1 chk("waw_block", {63'd0, bus_if.ex_ready}, 64'd0);
        chk("r6_hazard", {63'd0, hazard_stall}, 64'd1);
        tick();
        chk("waw_block2", {63'd0, bus_if.ex_ready}, 64'd0);
        state = `STATE_HALTED;
        bus_if.mem_rvalid = 1'b1;
        bus_if.mem_rdata  = 16'h0606;
        exp_q.push_back(mk(2'd2, 6'd6, 16'h0606));
        #1 chk("halt_ready_ret", {63'd0, bus_if.ex_ready}, 64'd0);
        tick();
        bus_if.mem_rvalid = 1'b0;
        #1 chk("halt_ready", {63'd0, bus_if.ex_ready}, 64'd0);
        chk("halt_haz_clear", {63'd0, hazard_stall}, 64'd0);
        state = 3'd0;
        #1 chk("unhalt_ready", {63'd0, bus_if.ex_ready}, 64'd1);
        exp_q.push_back(mk(2'd0, 6'd6, 16'h6666));
        tick();
        clr_op();
        rd_regnum1 = 6'd0;
        tick();

        // return with empty FIFO
        chk("err_before", {63'd0, ldq_err}, 64'd0);
        bus_if.mem_rvalid = 1'b1;
        bus_if.mem_rdata  = 16'hDEAD;
        tick();
        bus_if.mem_rvalid = 1'b0;
        chk("err_set", {63'd0, ldq_err}, 64'd1);
        tick();
        tick();
        chk("err_sticky", {63'd0, ldq_err}, 64'd1);
        rst = 1'b0;
        tick();
        chk("err_reset", {63'd0, ldq_err}, 64'd0);
        rst = 1'b1;
        repeat (3) tick();

        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/aap_writeback.md
# aap_writeback

Writeback stage placed directly upstream of the register file. It accepts retiring results from execute and load data returning from the data memory. It drives the register file's three write ports (a, b, d) one cycle later, and keeps a 16-entry pending-load scoreboard so decode can stall on hazards. Loads are tracked in an in-order FIFO because memory returns data in issue order.

## Interface
Parameters:
- LDQ_DEPTH, 4: pending-load FIFO entries (power of 2, 2..8)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk)
- state  in  3  processor state; `STATE_HALTED freezes writeback
- ex_valid  in  1  execute presents a retiring op
- ex_ready  out  1  op accepted this cycle when ex_valid && ex_ready
- ex_d_we  in  1  op writes a result register
- ex_d_regnum  in  6  result register (bits [3:0] used)
- ex_d_data  in  16  result value
- ex_b_we  in  1  op writes a base-pointer update (post-inc/pre-dec)
- ex_b_regnum  in  6  base register
- ex_b_data  in  16  updated pointer
- ex_is_load  in  1  op is a load; its destination is ex_d_regnum and ex_d_data is ignored
- mem_rvalid  in  1  load data returning (in order)
- mem_rdata  in  16  load data
- rd_regnum0/1/2  in  6 each  decode source registers to check
- hazard_stall  out  1  combinational: any rd_regnum has a pending load
- rega_wregnum/rega_wdata/rega_we  out  6/16/1  load-return write port
- regb_wregnum/regb_wdata/regb_we  out  6/16/1  base-update write port
- regd_wregnum/regd_wdata/regd_we  out  6/16/1  result write port
- ldq_err  out  1  sticky: mem_rvalid arrived while FIFO empty

## Operation
- Accept condition: ex_ready = rst && state != `STATE_HALTED && !(ex_is_load && ldq_full) && !(ex_d_we && pending[ex_d_regnum[3:0]]) && !(ex_b_we && pending[ex_b_regnum[3:0]]). The last two terms block WAW hazards against outstanding loads.
- On accept, non-load op: register ex_d into the regd port and ex_b into the regb port. Each we follows its input we.
- On accept, load: push ex_d_regnum[3:0] into the FIFO and set pending[reg]. regd_we = 0 for that op. The ex_b write proceeds normally.
- Load return (mem_rvalid && !empty): pop the head, drive the rega port with {2'b0, head} and mem_rdata, and clear pending[head]. If a load is accepted in the same cycle, push and pop both occur and the count is unchanged.
- Same-cycle collision on one register: the regd/regb write is the younger op and wins, so rega_we is suppressed for that register. regd and regb targeting the same register is illegal from execute. The block flags nothing and regd wins.
- mem_rvalid with FIFO empty: no write, ldq_err set until reset.
- While halted, the FIFO and scoreboard hold. mem_rvalid is still honoured, because memory cannot be stalled and loads must drain.
- Upper regnum bits [5:4] are output as 0.

## Timing
- Reset (rst=0 at posedge): FIFO empty, pending=0, ldq_err=0, all *_we=0, all wregnum/wdata=0. A reset mid-operation discards in-flight loads.
- Latency: accept or return at edge N, we high during cycle N+1 for exactly one cycle unless a new event arrives.
- The pending bit is set at the accept edge and cleared at the return edge. hazard_stall follows the registered pending vector, so it is visible in the cycle after accept.
- A full FIFO with a simultaneous pop still blocks a new load (ex_ready uses registered full). This is conservative.

## Configuration
- AAP_WB_BYPASS_EN defined: adds outputs fwd_valid (1) and fwd_data (16). When mem_rvalid pops a register matching any rd_regnum, hazard_stall is deasserted for that register in the same cycle, and fwd_data=mem_rdata with fwd_valid=1.
- Undefined: no fwd ports. hazard_stall stays high through the return cycle and clears the cycle after.

## Test plan
- Reset: hold rst=0 for 2 cycles with ex_valid=1 -> all we=0, ex_ready=0, hazard_stall=0, ldq_err=0.
- ALU op R3=0x1234, base R1=0x0102 -> next cycle regd_we=1/R3/0x1234 and regb_we=1/R1/0x0102, rega_we=0.
- Load to R5, rd_regnum0=5 -> hazard_stall=1 from the next cycle. mem_rvalid with 0xBEEF -> rega writes R5=0xBEEF, and hazard_stall drops (same cycle with AAP_WB_BYPASS_EN, next cycle without).
- Issue 4 loads to R1..R4 with no return -> 5th load ex_ready=0. One return plus a new load -> returns complete in order R1..R4 with matching data.
- Load to R6 pending, ALU op writing R6 -> ex_ready=0 until R6 returns. Halted state: ex_ready=0, but a pending return still writes.
- mem_rvalid with empty FIFO -> no we, ldq_err=1, stays set until rst=0.
